// File: rtl/switch_egress_port.sv
// switch_egress_port
// Egress side of one port of the 4-port switch. Packets forwarded by the
// crossbar mux are filtered against this port's identity, buffered in a
// small circular FIFO and presented on a registered valid/ready interface.
//
// Ports:
//   clk, rst_n   - rising-edge clock, asynchronous active-low reset
//   valid_in     - crossbar presents a packet this cycle
//   pkt_in       - {data[15:8], target[7:4], source[3:0]}
//   in_ready     - FIFO not full; the arbiter must not grant while low
//   valid_out    - output register holds a packet
//   source_out, target_out, data_out - fields of the held packet
//   ready_out    - downstream takes the held packet this cycle
//   drop_cnt     - saturating count of discarded packets
//   fifo_count   - current FIFO occupancy
module switch_egress_port #(
  parameter logic [3:0] PORT_MASK = 4'b0001,
  parameter int         DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic [15:0]              pkt_in,
  output logic                     in_ready,
  output logic                     valid_out,
  output logic [3:0]               source_out,
  output logic [3:0]               target_out,
  output logic [7:0]               data_out,
  input  logic                     ready_out,
  output logic [7:0]               drop_cnt,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state, next_state;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          fifo_full, fifo_empty;
  logic          target_hit, push, pop, drop;

  assign fifo_full  = (fifo_count == CW'(DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign in_ready   = !fifo_full;

  // A zero target never matches any mask bit, so it always falls into the drop path.
  assign target_hit = |(pkt_in[7:4] & PORT_MASK);
  assign push       = valid_in && in_ready && target_hit;
  assign drop       = valid_in && !(in_ready && target_hit);

  // Next-state logic; a pop is only requested when the FIFO holds data.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = SEND;
        end
      end
      SEND: begin
        if (ready_out) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= pkt_in;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // valid_out mirrors the registered FSM state; fields only change on a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out  <= 1'b0;
      source_out <= '0;
      target_out <= '0;
      data_out   <= '0;
    end else begin
      valid_out <= (next_state == SEND);
      if (pop) begin
        data_out   <= mem[rd_ptr][15:8];
        target_out <= mem[rd_ptr][7:4];
        source_out <= mem[rd_ptr][3:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_switch_egress_port.sv
// tb_switch_egress_port
// Directed bench for switch_egress_port. Accepted packets are pushed to a
// scoreboard queue when driven; a mid-cycle monitor pops and compares each
// packet the DUT hands over on a valid/ready handshake.
module tb_switch_egress_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [15:0] pkt_in;
  logic        in_ready;
  logic        valid_out;
  logic [3:0]  source_out;
  logic [3:0]  target_out;
  logic [7:0]  data_out;
  logic        ready_out;
  logic [7:0]  drop_cnt;
  logic [2:0]  fifo_count;

  int          checks  = 0;
  int          errors  = 0;
  int          rxCount = 0;
  logic [15:0] sb[$];

  switch_egress_port #(.PORT_MASK(4'b0001), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .pkt_in     (pkt_in),
    .in_ready   (in_ready),
    .valid_out  (valid_out),
    .source_out (source_out),
    .target_out (target_out),
    .data_out   (data_out),
    .ready_out  (ready_out),
    .drop_cnt   (drop_cnt),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one packet for one edge; packets expected to be accepted go to the scoreboard.
  task automatic applyStimulus(input logic [15:0] pkt, input bit accept);
    valid_in = 1'b1;
    pkt_in   = pkt;
    if (accept) sb.push_back(pkt);
    tick();
    valid_in = 1'b0;
  endtask

  // Mid-cycle monitor: a handshake will occur on the coming edge.
  always @(negedge clk) begin
    if (rst_n && valid_out && ready_out) begin
      logic [15:0] exp;
      rxCount++;
      checkOutput("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        checkOutput("pkt_out", {16'h0, data_out, target_out, source_out}, {16'h0, exp});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rxBase;
    int guard;
    logic [16:0] inReadyExp;
    logic [2:0]  countExp [6];
    countExp = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};

    rst_n = 1'b0; valid_in = 1'b0; ready_out = 1'b0; pkt_in = '0;
    #12;
    checkOutput("rst_valid_out", 32'(valid_out), 32'd0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    checkOutput("rst_fields", {20'h0, data_out, target_out, source_out}, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] single packet");
    ready_out = 1'b1;
    applyStimulus(16'hA512, 1'b1);
    checkOutput("single_count_after_accept", 32'(fifo_count), 32'd1);
    checkOutput("single_not_yet_valid", 32'(valid_out), 32'd0);
    tick();
    checkOutput("single_valid", 32'(valid_out), 32'd1);
    checkOutput("single_data", 32'(data_out), 32'hA5);
    checkOutput("single_target", 32'(target_out), 32'h1);
    checkOutput("single_source", 32'(source_out), 32'h2);
    tick();
    checkOutput("single_valid_low", 32'(valid_out), 32'd0);
    checkOutput("single_drop", 32'(drop_cnt), 32'd0);

    $display("[TB] filtering");
    rxBase = rxCount;
    applyStimulus(16'h0120, 1'b0);
    applyStimulus(16'h0200, 1'b0);
    applyStimulus(16'h03F0, 1'b1);
    repeat (3) tick();
    checkOutput("filter_drop", 32'(drop_cnt), 32'd2);
    checkOutput("filter_rx", 32'(rxCount - rxBase), 32'd1);
    checkOutput("filter_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] back-pressure and fill");
    ready_out = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      applyStimulus({8'(i), 4'h1, 4'h0}, i <= 5);
      checkOutput("fill_count", 32'(fifo_count), 32'(countExp[i-1]));
      inReadyExp = (countExp[i-1] != 3'd4) ? 17'd1 : 17'd0;
      checkOutput("fill_in_ready", 32'(in_ready), 32'(inReadyExp));
    end
    checkOutput("fill_drop", 32'(drop_cnt), 32'd3);
    checkOutput("fill_held_valid", 32'(valid_out), 32'd1);
    checkOutput("fill_held_data", 32'(data_out), 32'd1);
    ready_out = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      checkOutput("drain_valid", 32'(valid_out), 32'd1);
      checkOutput("drain_data", 32'(data_out), 32'(k));
      tick();
    end
    checkOutput("drain_valid_low", 32'(valid_out), 32'd0);

    $display("[TB] simultaneous push/pop");
    ready_out = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus({8'(8'h40 + i), 4'h1, 4'h5}, 1'b1);
    checkOutput("pp_count_start", 32'(fifo_count), 32'd2);
    ready_out = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus({8'(8'h43 + i), 4'h1, 4'h5}, 1'b1);
      checkOutput("pp_count", 32'(fifo_count), 32'd2);
      checkOutput("pp_no_gap", 32'(valid_out), 32'd1);
    end
    repeat (5) tick();
    checkOutput("pp_sb_empty", 32'(sb.size()), 32'd0);
    checkOutput("pp_idle", 32'(valid_out), 32'd0);

    $display("[TB] pointer wrap");
    rxBase = rxCount;
    ready_out = 1'b0;
    for (int i = 0; i < 20; i++) begin
      guard = 0;
      while (!in_ready && guard < 50) begin
        ready_out = ~ready_out;
        tick();
        guard++;
      end
      checkOutput("wrap_in_ready_wait", 32'(in_ready), 32'd1);
      ready_out = ~ready_out;
      applyStimulus({8'(i), 4'h1, 4'h3}, 1'b1);
    end
    repeat (20) begin
      ready_out = ~ready_out;
      tick();
    end
    checkOutput("wrap_rx", 32'(rxCount - rxBase), 32'd20);
    checkOutput("wrap_sb_empty", 32'(sb.size()), 32'd0);
    checkOutput("wrap_drop", 32'(drop_cnt), 32'd3);
    checkOutput("wrap_count", 32'(fifo_count), 32'd0);

    $display("[TB] reset mid-transfer");
    ready_out = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus({8'(8'h70 + i), 4'h1, 4'h9}, 1'b1);
    checkOutput("mid_count", 32'(fifo_count), 32'd3);
    checkOutput("mid_valid", 32'(valid_out), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(valid_out), 32'd0);
    checkOutput("mid_rst_count", 32'(fifo_count), 32'd0);
    checkOutput("mid_rst_drop", 32'(drop_cnt), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    #1 rst_n = 1'b1;
    ready_out = 1'b1;
    rxBase = rxCount;
    repeat (10) tick();
    checkOutput("post_rst_no_stale", 32'(rxCount - rxBase), 32'd0);
    checkOutput("post_rst_valid", 32'(valid_out), 32'd0);

    $display("[TB] drop saturation");
    ready_out = 1'b0;
    valid_in  = 1'b1;
    pkt_in    = 16'h5520;
    tick();
    checkOutput("sat_first", 32'(drop_cnt), 32'd1);
    repeat (253) tick();
    checkOutput("sat_254", 32'(drop_cnt), 32'hFE);
    tick();
    checkOutput("sat_255", 32'(drop_cnt), 32'hFF);
    repeat (45) tick();
    checkOutput("sat_300", 32'(drop_cnt), 32'hFF);
    checkOutput("sat_count", 32'(fifo_count), 32'd0);
    valid_in = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_egress_port.md
# switch_egress_port

Output side of one port of the 4-port switch. It accepts 16-bit packets `{data[7:0], target[3:0], source[3:0]}` that the 4:1 crossbar mux forwards after an ingress port wins arbitration. It filters out packets not addressed to this port, buffers accepted packets in a small FIFO, and presents them on a registered valid/ready output interface. It also exposes back-pressure to the arbiter and a saturating drop counter.

## Interface
- `PORT_MASK`, default 4'b0001: one-hot identity of this port. A packet is for this port when `(target & PORT_MASK) != 0`, so the broadcast target 4'b1111 is accepted.
- `DEPTH`, default 4: number of FIFO entries. Must be a power of two, ≥2.
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `valid_in` input 1: a mux packet is present this cycle.
- `pkt_in` input 16: `{data[15:8], target[7:4], source[3:0]}`.
- `in_ready` output 1: equals `!fifo_full`. The arbiter must not grant this port while it is low.
- `valid_out` output 1: the output register holds a packet.
- `source_out` output 4: source field of the held packet.
- `target_out` output 4: target field of the held packet.
- `data_out` output 8: payload of the held packet.
- `ready_out` input 1: downstream accepts the held packet this cycle.
- `drop_cnt` output 8: saturating count of discarded packets.
- `fifo_count` output $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **Accept.** On an edge with `valid_in && in_ready && (pkt_in[7:4] & PORT_MASK) != 0`, write `pkt_in` to the FIFO.
- **Drop.** On an edge with `valid_in` and either a mismatched target or `in_ready` low, do not write. Increment `drop_cnt`, saturating at 8'hFF.
- **Target 4'b0000.** Always a drop.
- **FSM states.** The FSM has two states, IDLE and SEND. Reset state is IDLE.
- **IDLE.** If the FIFO is non-empty: pop the head into the output register, set `valid_out`, and go to SEND. Otherwise stay in IDLE.
- **SEND.** `valid_out` is 1 and the output fields stay stable until handshake.
- **Handshake in SEND** (`ready_out` high): if the FIFO is non-empty in the same cycle, pop the next entry into the output register and stay in SEND; `valid_out` stays 1. If the FIFO is empty, clear `valid_out` and go to IDLE.
- **ready_out low in SEND.** Hold the state, the output register and `valid_out`.
- **FIFO.** Circular, with `$clog2(DEPTH)`-bit read/write pointers that wrap modulo DEPTH. Occupancy is tracked in `fifo_count`.
- **Full/empty.** `fifo_full = (fifo_count == DEPTH)` and `fifo_empty = (fifo_count == 0)`.
- **Same-cycle push and pop.** Both happen; `fifo_count` is unchanged.
- **Push when full.** Impossible, because `in_ready` is low; such a packet is counted as a drop.
- **Pop when empty.** Never issued.
- **Empty-FIFO bypass.** None. Every packet passes through the FIFO.

## Timing
- **Reset values.** `valid_out` 0, `source_out`/`target_out`/`data_out` 0, `drop_cnt` 0, `fifo_count` 0, `in_ready` 1, FSM in IDLE, pointers 0.
- **Reset mid-operation.** Asserting `rst_n` low forces all of the above immediately and flushes the FIFO contents. Any held packet is lost and not counted.
- **Latency.** A packet accepted at edge E shows up as `valid_out` = 1 after edge E+1 (the IDLE pop), provided the FIFO was empty and the FSM was in IDLE.
- **Throughput.** With `ready_out` held high, one packet per cycle is sustained.
- **in_ready.** Combinational from `fifo_count` only. It does not depend on `valid_in` or `ready_out` in the same cycle.
- **drop_cnt.** Updates on the edge the drop is sampled and is visible the next cycle.

## Test plan
- **Single packet.** Reset, then `valid_in` = 1 with `pkt_in` = 16'hA512 (target 4'b0001) for one cycle, `ready_out` = 1. Required: `valid_out` = 1 one cycle after the accept edge with `data_out` = 8'hA5, `target_out` = 4'h1, `source_out` = 4'h2. `valid_out` = 0 the cycle after. `drop_cnt` = 0.
- **Filtering.** Send targets 4'b0010, 4'b0000 and 4'b1111 (data 8'h01/02/03). Required: only the 8'h03 packet is emitted; `drop_cnt` = 2.
- **Back-pressure and fill.** Hold `ready_out` = 0 and send 6 matching packets, data 1..6, on consecutive cycles. Required:
  - `in_ready` falls after the FIFO holds 4 entries; the output register holds data 1.
  - `drop_cnt` = 1 (packet 6).
  - After raising `ready_out`, data 1,2,3,4,5 emerge on consecutive cycles with `valid_out` continuously high, and `valid_out` falls after data 5.
- **Simultaneous push/pop.** Keep the FIFO at 2 entries while pushing and accepting in the same cycles for 10 cycles. Required: `fifo_count` stays 2, output order matches input order, and there are no gaps.
- **Pointer wrap.** Stream 20 packets (data 0..19) with `ready_out` toggling 1/0 every cycle. Required: all 20 are emitted in order and `drop_cnt` = 0.
- **Reset mid-transfer.**
  - With 3 packets buffered and `valid_out` = 1, pulse `rst_n` low asynchronously between edges. Required: `valid_out`, `fifo_count` and `drop_cnt` go to 0 immediately.
  - After release, no stale packet is emitted.
  - The drop counter saturates at 8'hFF after 300 mismatched packets.
